ul4_acc: RTL and testbench

Sequential accumulator stage built around the 4-bit logic unit `ul4`. It accepts an operand B and an operation select over a valid/ready handshake, and drives `ul4` with A = accumulator and B = operand. It registers `ul4.Out` back into the accumulator and presents each result downstream over a second valid/ready handshake. It is the consumer of `ul4` results, and the first stateful stage of the logic datapath.

---
 rtl/ul4_pkg.sv | 19 +
 rtl/ul4_acc_if.sv | 31 +++
 rtl/ul4.sv | 23 ++
 rtl/ul4_acc.sv | 102 ++++++++++
 tb/tb_ul4_acc.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ul4_pkg.sv
// Shared definitions for the ul4 logic datapath.
// Holds the op-select encoding, the accumulator FSM state encoding and widths.
package ul4_pkg;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    localparam logic [1:0] UL4_AND  = 2'b00;
    localparam logic [1:0] UL4_OR   = 2'b01;
    localparam logic [1:0] UL4_XOR  = 2'b10;
    localparam logic [1:0] UL4_NOTB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/ul4_acc_if.sv
// Operand/result handshake bundle for the ul4 accumulator stage.
// The master side is the operand producer and result consumer.
// The slave side is the accumulator itself.
interface ul4_acc_if
    import ul4_pkg::*;
();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_s;
    logic             in_load;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_last;
    logic [CNT_W-1:0] op_cnt;

    modport master (
        output in_valid, in_b, in_s, in_load, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_last, op_cnt
    );

    modport slave (
        input  in_valid, in_b, in_s, in_load, in_last, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_last, op_cnt
    );

endinterface

// File: rtl/ul4.sv
// ul4: 4-bit combinational logic unit (AND / OR / XOR / NOT B).
module ul4
    import ul4_pkg::*;
(
    output logic [WIDTH-1:0] Out,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       s
);

    // Select one of the four bitwise functions of A and B.
    always_comb begin
        Out = {WIDTH{1'b0}};
        case (s)
            UL4_AND:  Out = A & B;
            UL4_OR:   Out = A | B;
            UL4_XOR:  Out = A ^ B;
            UL4_NOTB: Out = ~B;
            default:  Out = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/ul4_acc.sv
// ul4_acc: sequential accumulator around ul4.
// A beat is accepted in IDLE, evaluated in EXEC against the accumulator,
// and the result is held in HOLD until the downstream takes it. A result
// flagged last clears the accumulator once it has been delivered.
module ul4_acc
    import ul4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    ul4_acc_if.slave   bus
);

    state_t           state_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] b_r;
    logic [1:0]       s_r;
    logic             load_r;
    logic             last_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_last_r;
    logic [CNT_W-1:0] op_cnt_r;
    logic [WIDTH-1:0] ul4_out_s;
    logic [WIDTH-1:0] res_s;

    ul4 u_ul4 (
        .Out (ul4_out_s),
        .A   (acc_r),
        .B   (b_r),
        .s   (s_r)
    );

    // A load bypasses the logic unit and takes the operand as-is.
    always_comb begin
        res_s = ul4_out_s;
        if (load_r) begin
            res_s = b_r;
        end else begin
            res_s = ul4_out_s;
        end
    end

    // Control FSM with operand, accumulator, result and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            s_r         <= 2'b00;
            load_r      <= 1'b0;
            last_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_last_r  <= 1'b0;
            op_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // in_ready is high throughout IDLE once out of reset.
                    if (bus.in_valid) begin
                        b_r     <= bus.in_b;
                        s_r     <= bus.in_s;
                        load_r  <= bus.in_load;
                        last_r  <= bus.in_last;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    acc_r       <= res_s;
                    out_data_r  <= res_s;
                    out_valid_r <= 1'b1;
                    out_last_r  <= last_r;
                    op_cnt_r    <= op_cnt_r + 4'd1;
                    state_r     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        if (out_last_r) begin
                            acc_r <= {WIDTH{1'b0}};
                        end
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // in_ready is gated by rst_n so it reads 0 for the whole reset window,
    // yet is high on the first edge after release.
    assign bus.in_ready  = rst_n & (state_r == ST_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_zero  = (out_data_r == {WIDTH{1'b0}});
    assign bus.out_last  = out_last_r;
    assign bus.op_cnt    = op_cnt_r;

endmodule

// File: tb/tb_ul4_acc.sv
// Directed self-checking bench for ul4_acc with a transaction-level model.
module tb_ul4_acc;
    import ul4_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ul4_acc_if dut_if ();

    ul4_acc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if.slave)
    );

    typedef struct {
        logic [3:0] d;
        logic       l;
        logic [3:0] c;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    bit         lat_armed = 1'b0;
    int         hs_count = 0;
    logic [3:0] m_acc = 4'd0;
    logic [3:0] m_cnt = 4'd0;
    logic       prev_valid = 1'b0;
    logic [3:0] prev_data = 4'd0;
    logic       prev_last = 1'b0;
    logic       prev_zero = 1'b0;
    logic [3:0] got_d;
    logic       got_l;
    logic       got_z;
    logic [3:0] got_c;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ul4_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [1:0] s);
        case (s)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~b;
        endcase
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Model and compare process, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] r;
        if (!rst_n) begin
            exp_q.delete();
            m_acc      = 4'd0;
            m_cnt      = 4'd0;
            lat_armed  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (dut_if.in_valid && dut_if.in_ready) begin
                r = dut_if.in_load ? dut_if.in_b : ul4_model(m_acc, dut_if.in_b, dut_if.in_s);
                m_cnt = m_cnt + 4'd1;
                e.d = r;
                e.l = dut_if.in_last;
                e.c = m_cnt;
                exp_q.push_back(e);
                m_acc = dut_if.in_last ? 4'd0 : r;
                acc_cyc   = cyc;
                lat_armed = 1'b1;
            end
            if (dut_if.out_valid && !prev_valid) begin
                if (lat_armed) chk("latency", cyc - acc_cyc, 2);
                lat_armed = 1'b0;
            end
            if (dut_if.out_valid) chk("in_ready_while_valid", dut_if.in_ready, 0);
            if (prev_valid && dut_if.out_valid) begin
                chk("stable_data", dut_if.out_data, prev_data);
                chk("stable_last", dut_if.out_last, prev_last);
                chk("stable_zero", dut_if.out_zero, prev_zero);
            end
            if (dut_if.out_valid && dut_if.out_ready) begin
                hs_count++;
                chk("result_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("model_data", dut_if.out_data, e.d);
                    chk("model_zero", dut_if.out_zero, e.d == 4'd0);
                    chk("model_last", dut_if.out_last, e.l);
                    chk("model_cnt", dut_if.op_cnt, e.c);
                end
            end
            prev_valid = dut_if.out_valid;
            prev_data  = dut_if.out_data;
            prev_last  = dut_if.out_last;
            prev_zero  = dut_if.out_zero;
        end
    end

    task automatic send(input logic [3:0] b, input logic [1:0] s, input logic ld, input logic lst);
        bit ok = 1'b0;
        dut_if.in_valid = 1'b1;
        dut_if.in_b     = b;
        dut_if.in_s     = s;
        dut_if.in_load  = ld;
        dut_if.in_last  = lst;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dut_if.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        dut_if.in_valid = 1'b0;
        chk("accept_seen", ok, 1);
    endtask

    task automatic wait_result();
        bit ok = 1'b0;
        got_d = 4'd0; got_l = 1'b0; got_z = 1'b0; got_c = 4'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dut_if.out_valid && dut_if.out_ready) begin
                ok    = 1'b1;
                got_d = dut_if.out_data;
                got_l = dut_if.out_last;
                got_z = dut_if.out_zero;
                got_c = dut_if.op_cnt;
                break;
            end
        end
        chk("result_seen", ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_op(input string nm, input logic [3:0] b, input logic [1:0] s,
                         input logic ld, input logic lst, input logic [3:0] exp_d);
        send(b, s, ld, lst);
        wait_result();
        chk(nm, got_d, exp_d);
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dut_if.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("valid_seen", ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        bit ok;
        dut_if.in_valid  = 1'b0;
        dut_if.in_b      = 4'd0;
        dut_if.in_s      = 2'd0;
        dut_if.in_load   = 1'b0;
        dut_if.in_last   = 1'b0;
        dut_if.out_ready = 1'b1;

        // Reset values while rst_n is low.
        #12;
        chk("rst_in_ready", dut_if.in_ready, 0);
        chk("rst_out_valid", dut_if.out_valid, 0);
        chk("rst_out_data", dut_if.out_data, 0);
        chk("rst_out_zero", dut_if.out_zero, 1);
        chk("rst_out_last", dut_if.out_last, 0);
        chk("rst_op_cnt", dut_if.op_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Op sweep with out_ready held high.
        do_op("load_0011", 4'b0011, UL4_AND, 1'b1, 1'b0, 4'b0011);
        do_op("or_0101",   4'b0101, UL4_OR,  1'b0, 1'b0, 4'b0111);
        do_op("and_0110",  4'b0110, UL4_AND, 1'b0, 1'b0, 4'b0110);
        do_op("xor_1111",  4'b1111, UL4_XOR, 1'b0, 1'b0, 4'b1001);
        do_op("notb_0000", 4'b0000, UL4_NOTB, 1'b0, 1'b0, 4'b1111);
        chk("sweep_cnt", got_c, 5);

        // Backpressure: result 1010 held for 5 cycles with a beat waiting.
        dut_if.out_ready = 1'b0;
        send(4'b1010, UL4_AND, 1'b1, 1'b0);
        dut_if.in_valid = 1'b1;
        dut_if.in_b     = 4'b0001;
        dut_if.in_s     = UL4_OR;
        dut_if.in_load  = 1'b0;
        dut_if.in_last  = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", dut_if.out_data, 4'b1010);
            chk("bp_in_ready", dut_if.in_ready, 0);
            chk("bp_valid", dut_if.out_valid, 1);
            @(negedge clk);
        end
        hs0 = hs_count;
        @(posedge clk); #1;
        dut_if.out_ready = 1'b1;
        wait_result();
        chk("bp_release_data", got_d, 4'b1010);
        chk("bp_one_handshake", hs_count - hs0, 1);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dut_if.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_back_to_idle", ok, 1);
        @(posedge clk); #1;
        dut_if.in_valid = 1'b0;
        wait_result();
        chk("bp_pending_beat", got_d, 4'b1011);
        chk("bp_two_handshakes", hs_count - hs0, 2);
        chk("bp_cnt", got_c, 7);

        // Last / clear.
        do_op("load_last_1100", 4'b1100, UL4_AND, 1'b1, 1'b1, 4'b1100);
        chk("last_flag_set", got_l, 1);
        do_op("or_after_clear", 4'b0001, UL4_OR, 1'b0, 1'b0, 4'b0001);
        chk("last_flag_clear", got_l, 0);

        // Zero flag.
        do_op("load_0101", 4'b0101, UL4_AND, 1'b1, 1'b0, 4'b0101);
        chk("nonzero_flag", got_z, 0);
        do_op("xor_self", 4'b0101, UL4_XOR, 1'b0, 1'b0, 4'b0000);
        chk("zero_flag", got_z, 1);
        chk("zero_cnt", got_c, 11);

        // Counter wrap after 16 results.
        for (int i = 0; i < 5; i++) begin
            do_op("wrap_notb", 4'b0000, UL4_NOTB, 1'b0, 1'b0, 4'b1111);
        end
        chk("wrap_cnt", got_c, 0);

        // Reset in HOLD with a pending result.
        dut_if.out_ready = 1'b0;
        send(4'b0110, UL4_AND, 1'b1, 1'b0);
        wait_valid();
        hs0 = hs_count;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", dut_if.out_valid, 0);
        chk("mid_rst_out_data", dut_if.out_data, 0);
        chk("mid_rst_out_zero", dut_if.out_zero, 1);
        chk("mid_rst_out_last", dut_if.out_last, 0);
        chk("mid_rst_op_cnt", dut_if.op_cnt, 0);
        chk("mid_rst_in_ready", dut_if.in_ready, 0);
        @(posedge clk); #1;
        chk("mid_rst_no_handshake", hs_count - hs0, 0);
        rst_n = 1'b1;
        dut_if.out_ready = 1'b1;
        do_op("post_rst_or", 4'b0011, UL4_OR, 1'b0, 1'b0, 4'b0011);
        chk("post_rst_cnt", got_c, 1);

        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
